// File: rtl/data_mem_access_unit_if.sv
// Bundle of every signal the data memory access unit exchanges with the
// core (request/response), the register file and the data memory.
// The slave modport is the unit's view; master is the surrounding system.
interface data_mem_access_unit_if #(
  parameter int REG_BITS = 6
);
  // core request channel
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [31:0]         req_addr;
  logic [31:0]         req_wdata;
  logic [REG_BITS-1:0] req_rd;

  // core response channel
  logic                resp_valid;
  logic                resp_ready;
  logic [31:0]         resp_rdata;
  logic                resp_err;

  // register-file write port
  logic                reg_write;
  logic [REG_BITS-1:0] reg_rd;
  logic [31:0]         reg_data;

  // data memory port
  logic                mem_read;
  logic                mem_write;
  logic [31:0]         mem_address;
  logic [31:0]         mem_datain;
  logic [31:0]         mem_dataout;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_rd,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output reg_write, reg_rd, reg_data,
    output mem_read, mem_write, mem_address, mem_datain,
    input  mem_dataout
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  reg_write, reg_rd, reg_data,
    input  mem_read, mem_write, mem_address, mem_datain,
    output mem_dataout
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// Initiator for the single-port data memory. Takes one load/store at a
// time from the core, sequences the memory strobes, collects the registered
// read data and returns exactly one response per request. Clean loads are
// also written back to the register file on the response handshake.
// Every output comes straight from a register.
module data_mem_access_unit #(
  parameter int ADDR_BITS = 16,
  parameter int REG_BITS  = 6
) (
  input logic                   clock,
  input logic                   reset,
  data_mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STORE   = 3'd1,
    LOAD    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t              state_reg,       state_next;

  // latched request attributes needed after the accept edge
  logic                write_reg,       write_next;
  logic [REG_BITS-1:0] rd_reg,          rd_next;

  // output registers
  logic                req_ready_reg,   req_ready_next;
  logic                resp_valid_reg,  resp_valid_next;
  logic [31:0]         resp_rdata_reg,  resp_rdata_next;
  logic                resp_err_reg,    resp_err_next;
  logic                reg_write_reg,   reg_write_next;
  logic [REG_BITS-1:0] reg_rd_reg,      reg_rd_next;
  logic [31:0]         reg_data_reg,    reg_data_next;
  logic                mem_read_reg,    mem_read_next;
  logic                mem_write_reg,   mem_write_next;
  logic [31:0]         mem_address_reg, mem_address_next;
  logic [31:0]         mem_datain_reg,  mem_datain_next;

  // Address decode: anything above the decoded window is rejected without
  // touching memory; in-range addresses are zero-extended so the upper
  // bits of mem_address can never be non-zero.
  logic                out_of_range;
  logic [31:0]         in_range_addr;

  assign out_of_range  = |bus.req_addr[31:ADDR_BITS];
  assign in_range_addr = {{(32-ADDR_BITS){1'b0}}, bus.req_addr[ADDR_BITS-1:0]};

  // Next-state and next-output logic; every register holds unless told otherwise,
  // except the register-file strobe, which is a single-cycle pulse.
  always_comb begin
    state_next       = state_reg;
    write_next       = write_reg;
    rd_next          = rd_reg;
    req_ready_next   = req_ready_reg;
    resp_valid_next  = resp_valid_reg;
    resp_rdata_next  = resp_rdata_reg;
    resp_err_next    = resp_err_reg;
    reg_write_next   = 1'b0;
    reg_rd_next      = reg_rd_reg;
    reg_data_next    = reg_data_reg;
    mem_read_next    = mem_read_reg;
    mem_write_next   = mem_write_reg;
    mem_address_next = mem_address_reg;
    mem_datain_next  = mem_datain_reg;

    case (state_reg)
      IDLE: begin
        if (bus.req_valid && req_ready_reg) begin
          write_next     = bus.req_write;
          rd_next        = bus.req_rd;
          req_ready_next = 1'b0;
          if (out_of_range) begin
            // reject immediately: no strobe, mem_address left untouched
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
            resp_rdata_next = 32'h0;
          end else if (bus.req_write) begin
            state_next       = STORE;
            mem_write_next   = 1'b1;
            mem_address_next = in_range_addr;
            mem_datain_next  = bus.req_wdata;
          end else begin
            state_next       = LOAD;
            mem_read_next    = 1'b1;
            mem_address_next = in_range_addr;
          end
        end
      end

      STORE: begin
        // memory commits the write on the edge leaving this state
        mem_write_next  = 1'b0;
        state_next      = RESP;
        resp_valid_next = 1'b1;
        resp_err_next   = 1'b0;
        resp_rdata_next = 32'h0;
      end

      LOAD: begin
        // memory samples the read on the edge leaving this state
        mem_read_next = 1'b0;
        state_next    = CAPTURE;
      end

      CAPTURE: begin
        // dataout is valid for exactly this cycle
        resp_rdata_next = bus.mem_dataout;
        resp_err_next   = 1'b0;
        resp_valid_next = 1'b1;
        state_next      = RESP;
      end

      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_next = 1'b0;
          req_ready_next  = 1'b1;
          state_next      = IDLE;
          if (!write_reg && !resp_err_reg) begin
            reg_write_next = 1'b1;
            reg_rd_next    = rd_reg;
            reg_data_next  = resp_rdata_reg;
          end
        end
      end

      default: begin
        state_next      = IDLE;
        req_ready_next  = 1'b1;
        resp_valid_next = 1'b0;
        mem_read_next   = 1'b0;
        mem_write_next  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the strobes at once and
  // discards any request in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      write_reg       <= 1'b0;
      rd_reg          <= '0;
      req_ready_reg   <= 1'b1;
      resp_valid_reg  <= 1'b0;
      resp_rdata_reg  <= 32'h0;
      resp_err_reg    <= 1'b0;
      reg_write_reg   <= 1'b0;
      reg_rd_reg      <= '0;
      reg_data_reg    <= 32'h0;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      mem_address_reg <= 32'h0;
      mem_datain_reg  <= 32'h0;
    end else begin
      state_reg       <= state_next;
      write_reg       <= write_next;
      rd_reg          <= rd_next;
      req_ready_reg   <= req_ready_next;
      resp_valid_reg  <= resp_valid_next;
      resp_rdata_reg  <= resp_rdata_next;
      resp_err_reg    <= resp_err_next;
      reg_write_reg   <= reg_write_next;
      reg_rd_reg      <= reg_rd_next;
      reg_data_reg    <= reg_data_next;
      mem_read_reg    <= mem_read_next;
      mem_write_reg   <= mem_write_next;
      mem_address_reg <= mem_address_next;
      mem_datain_reg  <= mem_datain_next;
    end
  end

  assign bus.req_ready   = req_ready_reg;
  assign bus.resp_valid  = resp_valid_reg;
  assign bus.resp_rdata  = resp_rdata_reg;
  assign bus.resp_err    = resp_err_reg;
  assign bus.reg_write   = reg_write_reg;
  assign bus.reg_rd      = reg_rd_reg;
  assign bus.reg_data    = reg_data_reg;
  assign bus.mem_read    = mem_read_reg;
  assign bus.mem_write   = mem_write_reg;
  assign bus.mem_address = mem_address_reg;
  assign bus.mem_datain  = mem_datain_reg;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Self-checking bench for data_mem_access_unit: directed vector table,
// hand-written reset-during-load sequence and a random load/store stream
// checked against a reference word store.
module tb_data_mem_access_unit;

  logic clock;
  logic reset;

  data_mem_access_unit_if #(.REG_BITS(6)) bus ();

  data_mem_access_unit #(.ADDR_BITS(16), .REG_BITS(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // data memory: 64K words, registered read
  logic [31:0] mem [0:65535];
  always @(posedge clock) begin
    if (bus.mem_write) mem[bus.mem_address[15:0]] <= bus.mem_datain;
    if (bus.mem_read)  bus.mem_dataout <= mem[bus.mem_address[15:0]];
  end

  // reference contents, maintained by the bench from accepted stores
  logic [31:0] ref_mem [0:65535];

  int checks   = 0;
  int failures = 0;

  // strobe monitor
  int          both_cnt = 0;
  int          rd_cnt   = 0;
  int          wr_cnt   = 0;
  int          regw_cnt = 0;
  logic [31:0] last_addr = 32'h0;
  always @(negedge clock) begin
    if (bus.mem_read && bus.mem_write) both_cnt++;
    if (bus.mem_read)  begin rd_cnt++; last_addr = bus.mem_address; end
    if (bus.mem_write) begin wr_cnt++; last_addr = bus.mem_address; end
    if (bus.reg_write) regw_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // advance to just after the next falling edge
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  int txn = 0;

  // Issue one request, wait for the response, optionally stall the
  // handshake for `hold` cycles, then check writeback and strobe counts.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [5:0] rd, input logic exp_err,
                        input logic [31:0] exp_rdata, input int exp_lat, input int hold);
    int r0, w0, g0, lat;
    logic [31:0] held;
    logic exp_regw;
    r0 = rd_cnt; w0 = wr_cnt; g0 = regw_cnt;
    exp_regw = !w && !exp_err;
    chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_rd    = rd;
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("latency",    lat, exp_lat);
    chk("resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("resp_err",   {31'd0, bus.resp_err}, {31'd0, exp_err});
    chk("resp_rdata", bus.resp_rdata, exp_rdata);
    held = bus.resp_rdata;
    // stalled response; a stray request is offered and must be ignored
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h0000_0010;
        bus.req_wdata = 32'h0BAD_0BAD;
      end
      tick();
      chk("hold_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("hold_resp_rdata", bus.resp_rdata, held);
      chk("hold_req_ready",  {31'd0, bus.req_ready}, 32'd0);
      chk("hold_reg_write",  {31'd0, bus.reg_write}, 32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("post_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("post_req_ready",  {31'd0, bus.req_ready}, 32'd1);
    chk("reg_write",       {31'd0, bus.reg_write}, {31'd0, exp_regw});
    if (exp_regw) begin
      chk("reg_rd",   {26'd0, bus.reg_rd}, {26'd0, rd});
      chk("reg_data", bus.reg_data, exp_rdata);
    end
    tick();
    chk("reg_write_pulse", {31'd0, bus.reg_write}, 32'd0);
    chk("mem_read_cycles",  rd_cnt - r0,   (!w && !exp_err) ? 1 : 0);
    chk("mem_write_cycles", wr_cnt - w0,   ( w && !exp_err) ? 1 : 0);
    chk("reg_write_count",  regw_cnt - g0, exp_regw ? 1 : 0);
    if (!exp_err) chk("mem_address", last_addr, {16'd0, a[15:0]});
    if (w && !exp_err) ref_mem[a[15:0]] = d;
    $display("txn %0d %s addr=%h wdata=%h err=%0d rdata=%h lat=%0d",
             txn, w ? "store" : "load ", a, d, bus.resp_err, held, lat);
    txn++;
  endtask

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [5:0]  rd;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  lat;
    logic [3:0]  hold;
  } vec_t;

  vec_t vecs [0:10];

  initial begin
    logic        w;
    logic [31:0] a, d, exp_d;
    logic [5:0]  rd;
    logic        err;
    int          sel;

    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end

    //          w     addr           wdata          rd     err   rdata          lat   hold
    vecs[0]  = {1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 6'd0,  1'b0, 32'h0000_0000, 4'd2, 4'd0};
    vecs[1]  = {1'b0, 32'h0000_0010, 32'h0000_0000, 6'd5,  1'b0, 32'hDEAD_BEEF, 4'd3, 4'd0};
    vecs[2]  = {1'b0, 32'h0001_0000, 32'h0000_0000, 6'd7,  1'b1, 32'h0000_0000, 4'd1, 4'd0};
    vecs[3]  = {1'b0, 32'h0000_0010, 32'h0000_0000, 6'd9,  1'b0, 32'hDEAD_BEEF, 4'd3, 4'd5};
    vecs[4]  = {1'b1, 32'h0000_FFFF, 32'h1234_5678, 6'd0,  1'b0, 32'h0000_0000, 4'd2, 4'd0};
    vecs[5]  = {1'b0, 32'h0000_FFFF, 32'h0000_0000, 6'd63, 1'b0, 32'h1234_5678, 4'd3, 4'd0};
    vecs[6]  = {1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 6'd0,  1'b0, 32'h0000_0000, 4'd2, 4'd0};
    vecs[7]  = {1'b1, 32'h8000_0000, 32'h0000_0BAD, 6'd0,  1'b1, 32'h0000_0000, 4'd1, 4'd0};
    vecs[8]  = {1'b0, 32'h0000_0000, 32'h0000_0000, 6'd1,  1'b0, 32'hA5A5_A5A5, 4'd3, 4'd0};
    vecs[9]  = {1'b0, 32'h0000_0020, 32'h0000_0000, 6'd2,  1'b0, 32'h0000_0000, 4'd3, 4'd0};
    vecs[10] = {1'b1, 32'h0000_0010, 32'h0000_0001, 6'd0,  1'b0, 32'h0000_0000, 4'd2, 4'd3};

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_rd     = 6'd0;
    bus.resp_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // reset state
    chk("rst_req_ready",   {31'd0, bus.req_ready},  32'd1);
    chk("rst_resp_valid",  {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_err",    {31'd0, bus.resp_err},   32'd0);
    chk("rst_resp_rdata",  bus.resp_rdata,          32'd0);
    chk("rst_reg_write",   {31'd0, bus.reg_write},  32'd0);
    chk("rst_reg_rd",      {26'd0, bus.reg_rd},     32'd0);
    chk("rst_reg_data",    bus.reg_data,            32'd0);
    chk("rst_mem_read",    {31'd0, bus.mem_read},   32'd0);
    chk("rst_mem_write",   {31'd0, bus.mem_write},  32'd0);
    chk("rst_mem_address", bus.mem_address,         32'd0);
    chk("rst_mem_datain",  bus.mem_datain,          32'd0);

    // directed vector table
    for (int i = 0; i <= 10; i++) begin
      do_req(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].rd, vecs[i].err,
             vecs[i].rdata, int'(vecs[i].lat), int'(vecs[i].hold));
    end

    // reset asserted while the load strobe is out
    begin
      int g0;
      g0 = regw_cnt;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 32'h0000_0010;
      bus.req_rd    = 6'd3;
      tick();
      bus.req_valid = 1'b0;
      chk("rstload_mem_read_before", {31'd0, bus.mem_read}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rstload_mem_read_dropped", {31'd0, bus.mem_read}, 32'd0);
      chk("rstload_req_ready",        {31'd0, bus.req_ready}, 32'd1);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        chk("rstload_no_resp",   {31'd0, bus.resp_valid}, 32'd0);
        chk("rstload_req_ready", {31'd0, bus.req_ready}, 32'd1);
      end
      chk("rstload_no_reg_write", regw_cnt - g0, 0);
      $display("txn %0d reset during load: in-flight request discarded", txn);
      txn++;
      do_req(1'b1, 32'h0000_0030, 32'h5555_AAAA, 6'd0, 1'b0, 32'h0, 2, 0);
      do_req(1'b0, 32'h0000_0030, 32'h0, 6'd4, 1'b0, 32'h5555_AAAA, 3, 0);
    end

    // random stream against the reference store
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 32'h0002_0000 + $urandom_range(0, 255);
      else if (sel == 1) a = 32'h0000_FFFF;
      else               a = $urandom_range(0, 15);
      w     = 1'($urandom_range(0, 1));
      d     = $urandom;
      rd    = 6'($urandom_range(0, 63));
      err   = (a[31:16] != 16'd0);
      exp_d = (w || err) ? 32'h0 : ref_mem[a[15:0]];
      do_req(w, a, d, rd, err, exp_d, err ? 1 : (w ? 2 : 3), $urandom_range(0, 2));
    end

    chk("strobes_exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
